// File: rtl/ws2812b_pkg.sv
// Shared definitions for the WS2812B transmitter and receiver: default
// line timing in 50 MHz ticks, FSM state encodings and counter helpers.
package ws2812b_pkg;

  // Default line timing, in CLK50 ticks (20 ns each).
  localparam int D_THR  = 30;    // high time >= this decodes as a 1
  localparam int D_MINH = 5;     // shortest legal high pulse
  localparam int D_MAXH = 75;    // longest legal high pulse
  localparam int D_RST  = 2500;  // 50 us low = reset / latch gap

  // Width of the high/low pulse counters (holds D_RST with headroom).
  localparam int CNT_W = 12;
  typedef logic [CNT_W-1:0] cnt_t;

  // Receiver FSM encodings, also exported on the STATE debug port.
  localparam logic [2:0] ST_SYNC = 3'd0;  // waiting for a reset gap
  localparam logic [2:0] ST_IDLE = 3'd1;  // armed, line low
  localparam logic [2:0] ST_HI   = 3'd2;  // measuring a high pulse
  localparam logic [2:0] ST_LO   = 3'd3;  // measuring the low part of a bit
  localparam logic [2:0] ST_ERR  = 3'd4;  // framing error, waiting for a gap

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic cnt_t sat_inc(input cnt_t v);
    return (&v) ? v : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/ws2812b_pulse_meas.sv
// Pulse-width front end: synchronizes the serial line, detects its edges
// and measures the current high and low run lengths in whole ticks.
module ws2812b_pulse_meas
  import ws2812b_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic din_i,
  output logic rise_o,
  output logic fall_o,
  output cnt_t hi_cnt_o,
  output cnt_t lo_cnt_o
);

  logic sync1_q, sync2_q, prev_q;
  cnt_t hi_cnt_q, hi_cnt_d;
  cnt_t lo_cnt_q, lo_cnt_d;
  logic rise, fall;

  // Edges are seen in the first cycle the synchronized line has its new level.
  assign rise = sync2_q & ~prev_q;
  assign fall = ~sync2_q & prev_q;

  // Two-flop synchronizer plus one delayed copy for edge detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // High count restarts at 1 on a rising edge so that, in the falling-edge
  // cycle, it equals the number of ticks the line was high. Low count runs
  // while low and clears whenever the line is high.
  always_comb begin
    hi_cnt_d = hi_cnt_q;
    if (rise) begin
      hi_cnt_d = cnt_t'(1);
    end else if (sync2_q) begin
      hi_cnt_d = sat_inc(hi_cnt_q);
    end
    lo_cnt_d = sync2_q ? '0 : sat_inc(lo_cnt_q);
  end

  // Counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hi_cnt_q <= '0;
      lo_cnt_q <= '0;
    end else begin
      hi_cnt_q <= hi_cnt_d;
      lo_cnt_q <= lo_cnt_d;
    end
  end

  assign rise_o   = rise;
  assign fall_o   = fall;
  assign hi_cnt_o = hi_cnt_q;
  assign lo_cnt_o = lo_cnt_q;

endmodule

// File: rtl/ws2812b_rx.sv
// WS2812B receiver: decodes the serial pixel stream into 24-bit pixels and
// writes them to an external pixel memory, one write strobe per pixel.
module ws2812b_rx
  import ws2812b_pkg::*;
#(
  parameter int LEDS  = 256,
  parameter int dTHR  = D_THR,
  parameter int dMINH = D_MINH,
  parameter int dMAXH = D_MAXH,
  parameter int dRST  = D_RST
) (
  input  logic        CLK50,
  input  logic        RESET,
  input  logic        DIN,
  output logic [7:0]  MEM_A,
  output logic [23:0] MEM_D,
  output logic        MEM_WE,
  output logic        FRAME_DONE,
  output logic [8:0]  PIXELS,
  output logic        ERROR,
  output logic        OVERFLOW,
  output logic [2:0]  STATE
);

  // Timing thresholds sized to the counters they are compared against.
  localparam cnt_t       THR_C    = cnt_t'(dTHR);
  localparam cnt_t       MINH_C   = cnt_t'(dMINH);
  localparam cnt_t       MAXH_C   = cnt_t'(dMAXH);
  localparam cnt_t       RST_C    = cnt_t'(dRST);
  localparam logic [9:0] LEDS_C   = 10'(LEDS);
  localparam logic [8:0] PIX_MAX  = 9'h1FF;

  logic rise, fall;
  cnt_t hi_cnt, lo_cnt;

  logic [2:0]  state_q, state_d;
  logic [23:0] shift_q, shift_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic        full_q, full_d;
  logic [8:0]  pix_q, pix_d;
  logic        rise_pend_q, rise_pend_d;
  logic        mem_we_q, mem_we_d;
  logic [7:0]  mem_a_q, mem_a_d;
  logic [23:0] mem_d_q, mem_d_d;
  logic        frame_done_q, frame_done_d;
  logic [8:0]  pixels_q, pixels_d;
  logic        error_q, error_d;
  logic        overflow_q, overflow_d;

  ws2812b_pulse_meas u_meas (
    .clk_i    (CLK50),
    .rst_i    (RESET),
    .din_i    (DIN),
    .rise_o   (rise),
    .fall_o   (fall),
    .hi_cnt_o (hi_cnt),
    .lo_cnt_o (lo_cnt)
  );

  // Next-state logic: pixel write-out, frame/gap handling and bit decoding.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    full_d       = 1'b0;
    pix_d        = pix_q;
    rise_pend_d  = 1'b0;
    mem_we_d     = 1'b0;
    mem_a_d      = mem_a_q;
    mem_d_d      = mem_d_q;
    frame_done_d = 1'b0;
    pixels_d     = pixels_q;
    error_d      = error_q;
    overflow_d   = overflow_q;

    // The cycle after the 24th bit: write the pixel if it fits, then advance.
    if (full_q && (state_q != ST_ERR)) begin
      if ({1'b0, pix_q} < LEDS_C) begin
        mem_we_d = 1'b1;
        mem_a_d  = pix_q[7:0];
        mem_d_d  = shift_q;
      end else begin
        overflow_d = 1'b1;
      end
      if (pix_q != PIX_MAX) begin
        pix_d = pix_q + 9'd1;
      end
    end

    case (state_q)
      ST_SYNC, ST_ERR: begin
        // Only a full reset gap re-arms the receiver; no frame is reported.
        if (lo_cnt >= RST_C) begin
          state_d     = ST_IDLE;
          bit_cnt_d   = '0;
          pix_d       = '0;
          error_d     = 1'b0;
          overflow_d  = 1'b0;
          rise_pend_d = rise;
        end
      end
      ST_IDLE, ST_LO: begin
        // The gap beats a simultaneous rising edge; that edge is replayed
        // from IDLE on the following cycle via rise_pend.
        if (lo_cnt == RST_C) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
          pixels_d     = pix_q;
          bit_cnt_d    = '0;
          pix_d        = '0;
          error_d      = 1'b0;
          overflow_d   = 1'b0;
          rise_pend_d  = rise;
        end else if (rise || rise_pend_q) begin
          state_d = ST_HI;
        end
      end
      ST_HI: begin
        if (fall) begin
          if ((hi_cnt < MINH_C) || (hi_cnt > MAXH_C)) begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end else begin
            shift_d = {shift_q[22:0], (hi_cnt >= THR_C)};
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_d = '0;
              full_d    = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
            state_d = ST_LO;
          end
        end else if (hi_cnt > MAXH_C) begin
          // Line stuck high past the longest legal pulse.
          state_d = ST_ERR;
          error_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_SYNC;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK50 or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_SYNC;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      full_q       <= 1'b0;
      pix_q        <= '0;
      rise_pend_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_a_q      <= '0;
      mem_d_q      <= '0;
      frame_done_q <= 1'b0;
      pixels_q     <= '0;
      error_q      <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      full_q       <= full_d;
      pix_q        <= pix_d;
      rise_pend_q  <= rise_pend_d;
      mem_we_q     <= mem_we_d;
      mem_a_q      <= mem_a_d;
      mem_d_q      <= mem_d_d;
      frame_done_q <= frame_done_d;
      pixels_q     <= pixels_d;
      error_q      <= error_d;
      overflow_q   <= overflow_d;
    end
  end

  assign MEM_A      = mem_a_q;
  assign MEM_D      = mem_d_q;
  assign MEM_WE     = mem_we_q;
  assign FRAME_DONE = frame_done_q;
  assign PIXELS     = pixels_q;
  assign ERROR      = error_q;
  assign OVERFLOW   = overflow_q;
  assign STATE      = state_q;

endmodule

// File: tb/tb_ws2812b_rx.sv
// Self-checking bench for ws2812b_rx: two receivers (LEDS=256 and LEDS=2)
// share one serial line; expected writes go into a scoreboard queue when
// pixels are sent and are matched against writes recorded by a monitor.
`timescale 1ns/1ps
module tb_ws2812b_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;

  logic [7:0]  a1, a2;
  logic [23:0] d1, d2;
  logic        we1, we2, fdp1, fdp2, err1, err2, ov1, ov2;
  logic [8:0]  px1, px2;
  logic [2:0]  st1, st2;

  ws2812b_rx dut1 (
    .CLK50(clk), .RESET(rst), .DIN(din), .MEM_A(a1), .MEM_D(d1), .MEM_WE(we1),
    .FRAME_DONE(fdp1), .PIXELS(px1), .ERROR(err1), .OVERFLOW(ov1), .STATE(st1)
  );

  ws2812b_rx #(.LEDS(2)) dut2 (
    .CLK50(clk), .RESET(rst), .DIN(din), .MEM_A(a2), .MEM_D(d2), .MEM_WE(we2),
    .FRAME_DONE(fdp2), .PIXELS(px2), .ERROR(err2), .OVERFLOW(ov2), .STATE(st2)
  );

  always #10 clk = ~clk;

  // One memory write: which receiver, address, data, cycle it was seen.
  typedef struct packed {
    logic        id;
    logic [7:0]  a;
    logic [23:0] d;
    logic [31:0] c;
  } wr_t;

  wr_t exp_q[$];
  wr_t obs_q[$];
  int  rd_idx = 0;
  int  vectors = 0;
  int  miscompares = 0;
  int  fd1 = 0;
  int  fd2 = 0;
  int  pidx = 0;
  logic [31:0] cyc = '0;
  logic [31:0] last_fall = '0;

  always @(posedge clk) cyc <= cyc + 32'd1;

  // Monitor: records every write strobe and frame pulse, away from the edge.
  always @(negedge clk) begin
    if (we1) obs_q.push_back({1'b0, a1, d1, cyc});
    if (we2) obs_q.push_back({1'b1, a2, d2, cyc});
    if (fdp1) fd1 = fd1 + 1;
    if (fdp2) fd2 = fd2 + 1;
  end

  // One bit cell: th ticks high, then low for the rest of a 62-tick period.
  task automatic send_bit(input int th);
    din = 1'b1;
    repeat (th) @(negedge clk);
    din = 1'b0;
    last_fall = cyc;
    repeat ((th >= 52) ? 10 : 62 - th) @(negedge clk);
  endtask

  // One pixel MSB first; when valid, each receiver that has room for the
  // pixel is expected to write it 4 ticks after the last falling edge.
  task automatic send_pixel(input logic [23:0] d, input bit valid, input int th1, input int th0);
    for (int i = 23; i >= 0; i--) send_bit(d[i] ? th1 : th0);
    if (valid) begin
      exp_q.push_back({1'b0, 8'(pidx), d, last_fall + 32'd4});
      if (pidx < 2) exp_q.push_back({1'b1, 8'(pidx), d, last_fall + 32'd4});
      pidx++;
    end
    $display("sent pixel %06h valid=%0d", d, valid);
  endtask

  task automatic gap(input int n);
    din = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (5) @(negedge clk);
    vectors++;
    if ({st1, we1, fdp1, err1, ov1, a1, d1, px1} !== '0) begin
      miscompares++;
      $display("FAIL reset.outputs got st=%0d we=%0d fd=%0d err=%0d ov=%0d a=%0d d=%06h px=%0d, want all 0",
               st1, we1, fdp1, err1, ov1, a1, d1, px1);
    end
    rst = 1'b0;
    gap(3000);
    vectors++;
    if (st1 !== 3'd1 || fd1 != 0) begin
      miscompares++;
      $display("FAIL reset.armed got st=%0d fd=%0d, want st=1 fd=0", st1, fd1);
    end
  endtask

  task automatic test_frame();
    int fd0 = fd1;
    wr_t e, o;
    pidx = 0;
    send_pixel(24'hFF0000, 1'b1, 40, 20);
    send_pixel(24'h00FF00, 1'b1, 40, 20);
    send_pixel(24'h0000AA, 1'b1, 40, 20);
    gap(3000);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = '0;
      if (rd_idx < obs_q.size()) o = obs_q[rd_idx];
      rd_idx++; vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL frame.write got id%0d a=%0d d=%06h c=%0d, want id%0d a=%0d d=%06h c=%0d", o.id, o.a, o.d, o.c, e.id, e.a, e.d, e.c);
      end else $display("write id%0d a=%0d d=%06h", o.id, o.a, o.d);
    end
    vectors++;
    if (obs_q.size() != rd_idx) begin
      miscompares++; $display("FAIL frame.write_count got %0d want %0d", obs_q.size(), rd_idx); rd_idx = obs_q.size();
    end
    vectors++;
    if (fd1 - fd0 != 1 || px1 !== 9'd3 || px2 !== 9'd3 || err1 !== 1'b0 || st1 !== 3'd1) begin
      miscompares++;
      $display("FAIL frame.status got fd=%0d px1=%0d px2=%0d err=%0d st=%0d, want fd=1 px1=3 px2=3 err=0 st=1",
               fd1 - fd0, px1, px2, err1, st1);
    end
  endtask

  task automatic test_threshold();
    int fd0 = fd1;
    wr_t e, o;
    pidx = 0;
    send_pixel(24'hA5C3F0, 1'b1, 30, 29);   // 30 -> 1, 29 -> 0
    send_pixel(24'h5A3C0F, 1'b1, 75, 5);    // longest and shortest legal highs
    gap(3000);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = '0;
      if (rd_idx < obs_q.size()) o = obs_q[rd_idx];
      rd_idx++; vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL threshold.write got id%0d a=%0d d=%06h c=%0d, want id%0d a=%0d d=%06h c=%0d", o.id, o.a, o.d, o.c, e.id, e.a, e.d, e.c);
      end else $display("write id%0d a=%0d d=%06h", o.id, o.a, o.d);
    end
    vectors++;
    if (obs_q.size() != rd_idx) begin
      miscompares++; $display("FAIL threshold.write_count got %0d want %0d", obs_q.size(), rd_idx); rd_idx = obs_q.size();
    end
    vectors++;
    if (fd1 - fd0 != 1 || px1 !== 9'd2 || err1 !== 1'b0) begin
      miscompares++;
      $display("FAIL threshold.status got fd=%0d px=%0d err=%0d, want fd=1 px=2 err=0", fd1 - fd0, px1, err1);
    end
  endtask

  task automatic test_glitch();
    int fd0 = fd1;
    wr_t e, o;
    pidx = 0;
    send_pixel(24'h123456, 1'b1, 40, 20);
    for (int i = 0; i < 10; i++) send_bit(i[0] ? 40 : 20);
    send_bit(3);
    vectors++;
    if (err1 !== 1'b1 || st1 !== 3'd4) begin
      miscompares++; $display("FAIL glitch.error got err=%0d st=%0d, want err=1 st=4", err1, st1);
    end
    for (int i = 0; i < 13; i++) send_bit(40);
    gap(3000);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = '0;
      if (rd_idx < obs_q.size()) o = obs_q[rd_idx];
      rd_idx++; vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL glitch.write got id%0d a=%0d d=%06h c=%0d, want id%0d a=%0d d=%06h c=%0d", o.id, o.a, o.d, o.c, e.id, e.a, e.d, e.c);
      end else $display("write id%0d a=%0d d=%06h", o.id, o.a, o.d);
    end
    vectors++;
    if (obs_q.size() != rd_idx) begin
      miscompares++; $display("FAIL glitch.write_count got %0d want %0d", obs_q.size(), rd_idx); rd_idx = obs_q.size();
    end
    vectors++;
    if (fd1 != fd0 || err1 !== 1'b0 || st1 !== 3'd1) begin
      miscompares++;
      $display("FAIL glitch.recover got fd=%0d err=%0d st=%0d, want fd=0 err=0 st=1", fd1 - fd0, err1, st1);
    end
    pidx = 0;
    send_pixel(24'hC0FFEE, 1'b1, 40, 20);
    gap(3000);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = '0;
      if (rd_idx < obs_q.size()) o = obs_q[rd_idx];
      rd_idx++; vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL glitch.next_write got id%0d a=%0d d=%06h c=%0d, want id%0d a=%0d d=%06h c=%0d", o.id, o.a, o.d, o.c, e.id, e.a, e.d, e.c);
      end else $display("write id%0d a=%0d d=%06h", o.id, o.a, o.d);
    end
    vectors++;
    if (obs_q.size() != rd_idx || fd1 - fd0 != 1 || px1 !== 9'd1) begin
      miscompares++;
      $display("FAIL glitch.next_frame got writes=%0d fd=%0d px=%0d, want writes=%0d fd=1 px=1", obs_q.size(), fd1 - fd0, px1, rd_idx);
      rd_idx = obs_q.size();
    end
  endtask

  task automatic test_overflow();
    int fd0 = fd2;
    wr_t e, o;
    pidx = 0;
    send_pixel(24'h010203, 1'b1, 40, 20);
    send_pixel(24'h040506, 1'b1, 40, 20);
    send_pixel(24'h070809, 1'b1, 40, 20);
    gap(10);
    vectors++;
    if (ov2 !== 1'b1 || ov1 !== 1'b0) begin
      miscompares++; $display("FAIL overflow.flag got ov2=%0d ov1=%0d, want ov2=1 ov1=0", ov2, ov1);
    end
    gap(3000);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = '0;
      if (rd_idx < obs_q.size()) o = obs_q[rd_idx];
      rd_idx++; vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL overflow.write got id%0d a=%0d d=%06h c=%0d, want id%0d a=%0d d=%06h c=%0d", o.id, o.a, o.d, o.c, e.id, e.a, e.d, e.c);
      end else $display("write id%0d a=%0d d=%06h", o.id, o.a, o.d);
    end
    vectors++;
    if (obs_q.size() != rd_idx) begin
      miscompares++; $display("FAIL overflow.write_count got %0d want %0d", obs_q.size(), rd_idx); rd_idx = obs_q.size();
    end
    vectors++;
    if (px2 !== 9'd3 || fd2 - fd0 != 1 || ov2 !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow.frame got px=%0d fd=%0d ov=%0d, want px=3 fd=1 ov=0", px2, fd2 - fd0, ov2);
    end
  endtask

  task automatic test_partial();
    int fd0 = fd1;
    for (int i = 0; i < 12; i++) send_bit(40);
    gap(3000);
    vectors++;
    if (obs_q.size() != rd_idx) begin
      miscompares++; $display("FAIL partial.write_count got %0d want %0d", obs_q.size(), rd_idx); rd_idx = obs_q.size();
    end
    vectors++;
    if (fd1 - fd0 != 1 || px1 !== 9'd0) begin
      miscompares++; $display("FAIL partial.frame got fd=%0d px=%0d, want fd=1 px=0", fd1 - fd0, px1);
    end
  endtask

  task automatic test_reset_midframe();
    int fd0 = fd1;
    wr_t e, o;
    for (int i = 0; i < 10; i++) send_bit(40);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (st1 !== 3'd0 || px1 !== 9'd0) begin
      miscompares++; $display("FAIL midreset.state got st=%0d px=%0d, want st=0 px=0", st1, px1);
    end
    send_pixel(24'hFFFFFF, 1'b0, 40, 20);
    send_pixel(24'h0F0F0F, 1'b0, 40, 20);
    gap(100);
    vectors++;
    if (st1 !== 3'd0 || obs_q.size() != rd_idx) begin
      miscompares++; $display("FAIL midreset.ignored got st=%0d writes=%0d, want st=0 writes=%0d", st1, obs_q.size(), rd_idx);
      rd_idx = obs_q.size();
    end
    gap(2900);
    vectors++;
    if (st1 !== 3'd1 || fd1 != fd0 || obs_q.size() != rd_idx) begin
      miscompares++; $display("FAIL midreset.rearm got st=%0d fd=%0d writes=%0d, want st=1 fd=0 writes=%0d", st1, fd1 - fd0, obs_q.size(), rd_idx);
      rd_idx = obs_q.size();
    end
    pidx = 0;
    send_pixel(24'hBEEF01, 1'b1, 40, 20);
    gap(3000);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = '0;
      if (rd_idx < obs_q.size()) o = obs_q[rd_idx];
      rd_idx++; vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL midreset.write got id%0d a=%0d d=%06h c=%0d, want id%0d a=%0d d=%06h c=%0d", o.id, o.a, o.d, o.c, e.id, e.a, e.d, e.c);
      end else $display("write id%0d a=%0d d=%06h", o.id, o.a, o.d);
    end
    vectors++;
    if (obs_q.size() != rd_idx || fd1 - fd0 != 1 || px1 !== 9'd1) begin
      miscompares++;
      $display("FAIL midreset.frame got writes=%0d fd=%0d px=%0d, want writes=%0d fd=1 px=1", obs_q.size(), fd1 - fd0, px1, rd_idx);
      rd_idx = obs_q.size();
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_threshold();
    test_glitch();
    test_overflow();
    test_partial();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
